unique_value_counter: RTL and testbench

Scan controller for the single-ported inferred RAM in the count-unique-values design. On a start pulse it walks every RAM address in order and accounts for the one-cycle registered read latency. Each returned word is tested against an internal presence bitmap, and the block counts how many distinct in-range values the RAM holds. It owns the RAM port for the whole scan and reports the result with a one-cycle done pulse.

---
 rtl/uvc_pkg.sv | 15 +
 rtl/ram_single_ported_inferred.sv | 20 ++
 rtl/uvc_bitmap.sv | 26 ++
 rtl/unique_value_counter.sv | 92 +++++++++
 tb/tb_unique_value_counter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/uvc_pkg.sv
// Shared types and width helpers for the unique-value scan controller.
package uvc_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  // Counter width must hold the value NUM_WORDS itself.
  function automatic int uvc_cnt_w(input int num_words);
    return $clog2(num_words + 1);
  endfunction

  function automatic int uvc_idx_w(input int value_range);
    return (value_range > 1) ? $clog2(value_range) : 1;
  endfunction

endpackage

// File: rtl/ram_single_ported_inferred.sv
// Single-ported inferred RAM with one-cycle registered read.
module ram_single_ported_inferred #(
  parameter int NUM_WORD_BITS = 32,
  parameter int NUM_WORDS     = 1024
) (
  input  logic                         clk,
  input  logic                         write_enable,
  input  logic [$clog2(NUM_WORDS)-1:0] address,
  input  logic [NUM_WORD_BITS-1:0]     data_in,
  output logic [NUM_WORD_BITS-1:0]     data_out
);

  logic [NUM_WORD_BITS-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (write_enable) mem[address] <= data_in;
    data_out <= mem[address];
  end

endmodule

// File: rtl/uvc_bitmap.sv
// Presence bitmap: synchronous clear plus one test-and-set port per cycle.
module uvc_bitmap
  import uvc_pkg::*;
#(
  parameter int VALUE_RANGE = 256,
  parameter int IDX_W       = uvc_idx_w(VALUE_RANGE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_en,
  input  logic [IDX_W-1:0] idx,
  output logic             was_set
);

  logic [VALUE_RANGE-1:0] bits;

  // Reports the bit before this cycle's set takes effect.
  assign was_set = bits[idx];

  always_ff @(posedge clk) begin
    if (reset || clear) bits <= '0;
    else if (set_en)    bits[idx] <= 1'b1;
  end

endmodule

// File: rtl/unique_value_counter.sv
// Scans every RAM address once and counts distinct values below VALUE_RANGE.
// Optional out-of-range word counter: define UVC_OOR_COUNT_EN.
module unique_value_counter
  import uvc_pkg::*;
#(
  parameter int NUM_WORD_BITS = 32,
  parameter int NUM_WORDS     = 1024,
  parameter int VALUE_RANGE   = 256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [uvc_cnt_w(NUM_WORDS)-1:0]   unique_count_out,
`ifdef UVC_OOR_COUNT_EN
  output logic [uvc_cnt_w(NUM_WORDS)-1:0]   oor_count_out,
`endif
  output logic                              ram_write_enable_out,
  output logic [$clog2(NUM_WORDS)-1:0]      ram_address_out,
  output logic [NUM_WORD_BITS-1:0]          ram_data_out,
  input  logic [NUM_WORD_BITS-1:0]          ram_data_in
);

  localparam int CNT_W  = uvc_cnt_w(NUM_WORDS);
  localparam int IDX_W  = uvc_idx_w(VALUE_RANGE);
  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t state, state_nxt;
  logic   start_acc, rd_valid, in_range, was_set, set_en;

  assign ram_write_enable_out = 1'b0;
  assign ram_data_out         = '0;
  assign busy_out             = (state != IDLE);
  assign done_out             = (state == DONE);
  assign start_acc            = (state == IDLE) && start_in;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_in) state_nxt = SCAN;
      SCAN:  if (ram_address_out == LAST_ADDR) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address parks on the last word after the scan; it never wraps.
  always_ff @(posedge clk) begin
    if (reset || start_acc) ram_address_out <= '0;
    else if (state == SCAN && ram_address_out != LAST_ADDR)
      ram_address_out <= ram_address_out + ADDR_W'(1);
  end

  // Read data lags the address by one cycle.
  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= (state == SCAN);
  end

  assign in_range = (ram_data_in < NUM_WORD_BITS'(VALUE_RANGE));
  assign set_en   = rd_valid && in_range;

  uvc_bitmap #(.VALUE_RANGE(VALUE_RANGE), .IDX_W(IDX_W)) u_bitmap (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc),
    .set_en  (set_en),
    .idx     (ram_data_in[IDX_W-1:0]),
    .was_set (was_set)
  );

  always_ff @(posedge clk) begin
    if (reset || start_acc)   unique_count_out <= '0;
    else if (set_en && !was_set) unique_count_out <= unique_count_out + CNT_W'(1);
  end

`ifdef UVC_OOR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc)      oor_count_out <= '0;
    else if (rd_valid && !in_range) oor_count_out <= oor_count_out + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_unique_value_counter.sv
// Directed bench for unique_value_counter with a 16-word RAM and 8-value bitmap.
module tb_unique_value_counter;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int VR = 8;
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start_in, busy_out, done_out, ram_write_enable_out;
  logic [CW-1:0] unique_count_out;
`ifdef UVC_OOR_COUNT_EN
  logic [CW-1:0] oor_count_out;
`endif
  logic [AW-1:0] ram_address_out;
  logic [W-1:0]  ram_data_out, ram_q;

  // Bench takes over the RAM port only while loading contents.
  logic          load, load_we;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_d;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [W-1:0]  ram_d;
  assign ram_we = load ? load_we   : ram_write_enable_out;
  assign ram_a  = load ? load_addr : ram_address_out;
  assign ram_d  = load ? load_d    : ram_data_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] pat [N];

  unique_value_counter #(.NUM_WORD_BITS(W), .NUM_WORDS(N), .VALUE_RANGE(VR)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start_in             (start_in),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .unique_count_out     (unique_count_out),
`ifdef UVC_OOR_COUNT_EN
    .oor_count_out        (oor_count_out),
`endif
    .ram_write_enable_out (ram_write_enable_out),
    .ram_address_out      (ram_address_out),
    .ram_data_out         (ram_data_out),
    .ram_data_in          (ram_q)
  );

  ram_single_ported_inferred #(.NUM_WORD_BITS(W), .NUM_WORDS(N)) u_ram (
    .clk          (clk),
    .write_enable (ram_we),
    .address      (ram_a),
    .data_in      (ram_d),
    .data_out     (ram_q)
  );

  task automatic load_ram();
    load = 1'b1;
    for (int i = 0; i < N; i++) begin
      load_we = 1'b1; load_addr = AW'(i); load_d = pat[i];
      @(posedge clk); #1;
    end
    load = 1'b0; load_we = 1'b0;
  endtask

  // Start in cycle T, then check every cycle T+1..T+19.
  task automatic run_scan(input string name, input int exp_u, input int exp_o, input bit pokes);
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int k = 1; k <= N + 3; k++) begin
      logic          eb, ed;
      logic [AW-1:0] ea;
      @(negedge clk);
      eb = (k <= N + 2);
      ed = (k == N + 2);
      ea = (k <= N) ? AW'(k - 1) : AW'(N - 1);
      n_cmp++;
      if (busy_out !== eb) begin
        n_bad++; $display("FAIL %s busy k=%0d got %0b exp %0b", name, k, busy_out, eb);
      end
      n_cmp++;
      if (done_out !== ed) begin
        n_bad++; $display("FAIL %s done k=%0d got %0b exp %0b", name, k, done_out, ed);
      end
      n_cmp++;
      if (ram_address_out !== ea) begin
        n_bad++; $display("FAIL %s addr k=%0d got %0d exp %0d", name, k, ram_address_out, ea);
      end
      n_cmp++;
      if (ram_write_enable_out !== 1'b0 || ram_data_out !== '0) begin
        n_bad++; $display("FAIL %s ram_we/data k=%0d got %0b/%0h exp 0/0", name, k,
                          ram_write_enable_out, ram_data_out);
      end
      if (k >= N + 2) begin
        n_cmp++;
        if (unique_count_out !== CW'(exp_u)) begin
          n_bad++; $display("FAIL %s unique k=%0d got %0d exp %0d", name, k, unique_count_out, exp_u);
        end
`ifdef UVC_OOR_COUNT_EN
        n_cmp++;
        if (oor_count_out !== CW'(exp_o)) begin
          n_bad++; $display("FAIL %s oor k=%0d got %0d exp %0d", name, k, oor_count_out, exp_o);
        end
`endif
      end
      // Pulses mid-scan and in the done cycle must all be ignored.
      start_in = pokes && (k == 3 || k == 10 || k == N + 2);
      @(posedge clk); #1;
    end
    start_in = 1'b0;
    if (exp_o < 0) $display("unexpected oor expectation in %s", name);
  endtask

  task automatic test_reset();
    reset = 1'b1; start_in = 1'b0; load = 1'b0; load_we = 1'b0;
    load_addr = '0; load_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || unique_count_out !== '0 ||
        ram_address_out !== '0 || ram_write_enable_out !== 1'b0 || ram_data_out !== '0) begin
      n_bad++; $display("FAIL reset outputs got busy=%0b done=%0b uniq=%0d addr=%0d we=%0b exp all 0",
                        busy_out, done_out, unique_count_out, ram_address_out, ram_write_enable_out);
    end
`ifdef UVC_OOR_COUNT_EN
    n_cmp++;
    if (oor_count_out !== '0) begin
      n_bad++; $display("FAIL reset oor got %0d exp 0", oor_count_out);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_all_distinct();
    for (int i = 0; i < N; i++) pat[i] = W'(i);
    load_ram();
    run_scan("distinct", 8, 8, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      if (k == 6) begin
        n_cmp++;
        if (busy_out !== 1'b0 || unique_count_out !== '0 || ram_address_out !== '0) begin
          n_bad++; $display("FAIL midreset outputs got busy=%0b uniq=%0d addr=%0d exp 0/0/0",
                            busy_out, unique_count_out, ram_address_out);
        end
`ifdef UVC_OOR_COUNT_EN
        n_cmp++;
        if (oor_count_out !== '0) begin
          n_bad++; $display("FAIL midreset oor got %0d exp 0", oor_count_out);
        end
`endif
        reset = 1'b0;
      end
      if (k >= 6) begin
        n_cmp++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
          n_bad++; $display("FAIL midreset idle k=%0d got done=%0b busy=%0b exp 0/0", k, done_out, busy_out);
        end
      end
      if (k == 5) reset = 1'b1;
      @(posedge clk); #1;
    end
    run_scan("after_reset", 8, 8, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) pat[i] = W'(3);
    load_ram();
    run_scan("equal_1", 1, 0, 1'b0);
    run_scan("equal_2", 1, 0, 1'b0);
  endtask

  task automatic test_repeats();
    int rep [6] = '{5, 5, 2, 7, 2, 0};
    for (int i = 0; i < N; i++) pat[i] = W'(rep[i % 6]);
    load_ram();
    run_scan("repeats", 4, 0, 1'b1);
  endtask

  task automatic test_boundary();
    for (int i = 0; i < N; i++) pat[i] = (i % 2 == 0) ? W'(7) : W'(8);
    pat[N-1] = W'(32'h8000_0007);
    load_ram();
    run_scan("boundary", 1, 8, 1'b0);
  endtask

  initial begin
    test_reset();
    test_all_distinct();
    test_reset_mid_scan();
    test_back_to_back();
    test_repeats();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
